// File: rtl/rv32i_inst_encoder.sv
// Packs an op descriptor (op, rd, rs1, rs2, imm) into an RV32I instruction word.
// Words stream out through one registered stage, each tagged with a running IMEM word address.
module rv32i_inst_encoder #(
    parameter int unsigned ADDR_W    = 14,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              restart,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic              err_sticky
);

    localparam logic [5:0] OP_LUI  = 6'd0,  OP_AUIPC = 6'd1,  OP_JAL  = 6'd2,  OP_JALR  = 6'd3;
    localparam logic [5:0] OP_BEQ  = 6'd4,  OP_BNE   = 6'd5,  OP_BLT  = 6'd6,  OP_BGE   = 6'd7;
    localparam logic [5:0] OP_BLTU = 6'd8,  OP_BGEU  = 6'd9;
    localparam logic [5:0] OP_SB   = 6'd10, OP_SH    = 6'd11, OP_SW   = 6'd12;
    localparam logic [5:0] OP_LB   = 6'd13, OP_LH    = 6'd14, OP_LW   = 6'd15;
    localparam logic [5:0] OP_LBU  = 6'd16, OP_LHU   = 6'd17;
    localparam logic [5:0] OP_ADDI = 6'd18, OP_SLTI  = 6'd19, OP_SLTIU = 6'd20, OP_XORI = 6'd21;
    localparam logic [5:0] OP_ORI  = 6'd22, OP_ANDI  = 6'd23, OP_SLLI  = 6'd24, OP_SRLI = 6'd25;
    localparam logic [5:0] OP_SRAI = 6'd26;
    localparam logic [5:0] OP_ADD  = 6'd27, OP_SUB   = 6'd28, OP_SLL  = 6'd29, OP_SLT   = 6'd30;
    localparam logic [5:0] OP_SLTU = 6'd31, OP_XOR   = 6'd32, OP_SRL  = 6'd33, OP_SRA   = 6'd34;
    localparam logic [5:0] OP_OR   = 6'd35, OP_AND   = 6'd36;

    localparam logic [31:0]       NOP  = 32'h0000_0013;
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] load_addr;
    logic [31:0]       enc;
    logic              bad;
    logic [2:0]        f3;
    logic              xfer;
    logic              s12, s13, s21;

    assign in_ready  = !out_valid || out_ready;
    assign xfer      = in_valid && in_ready;
    assign load_addr = restart ? BASE : cnt;

    // Sign-range checks: every bit above the sign bit must copy it.
    assign s12 = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
    assign s13 = (in_imm[31:12] == '0) || (in_imm[31:12] == '1);
    assign s21 = (in_imm[31:20] == '0) || (in_imm[31:20] == '1);

    always_comb begin
        f3 = 3'b000;
        case (in_op)
            OP_BNE, OP_SH, OP_LH, OP_SLLI, OP_SLL:                   f3 = 3'b001;
            OP_SW, OP_LW, OP_SLTI, OP_SLT:                           f3 = 3'b010;
            OP_SLTIU, OP_SLTU:                                       f3 = 3'b011;
            OP_BLT, OP_LBU, OP_XORI, OP_XOR:                         f3 = 3'b100;
            OP_BGE, OP_LHU, OP_SRLI, OP_SRAI, OP_SRL, OP_SRA:        f3 = 3'b101;
            OP_BLTU, OP_ORI, OP_OR:                                  f3 = 3'b110;
            OP_BGEU, OP_ANDI, OP_AND:                                f3 = 3'b111;
            default:                                                 f3 = 3'b000;
        endcase
    end

    always_comb begin
        enc = NOP;
        bad = 1'b0;
        case (in_op)
            OP_LUI: begin
                enc = {in_imm[31:12], in_rd, 7'b0110111};
                bad = |in_imm[11:0];
            end
            OP_AUIPC: begin
                enc = {in_imm[31:12], in_rd, 7'b0010111};
                bad = |in_imm[11:0];
            end
            OP_JAL: begin
                enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
                bad = !s21 || in_imm[0];
            end
            OP_JALR: begin
                enc = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b1100111};
                bad = !s12;
            end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3, in_imm[4:1], in_imm[11], 7'b1100011};
                bad = !s13 || in_imm[0];
            end
            OP_SB, OP_SH, OP_SW: begin
                enc = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], 7'b0100011};
                bad = !s12;
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                enc = {in_imm[11:0], in_rs1, f3, in_rd, 7'b0000011};
                bad = !s12;
            end
            OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI: begin
                enc = {in_imm[11:0], in_rs1, f3, in_rd, 7'b0010011};
                bad = !s12;
            end
            OP_SLLI, OP_SRLI, OP_SRAI: begin
                enc = {1'b0, in_op == OP_SRAI, 5'b00000, in_imm[4:0], in_rs1, f3, in_rd, 7'b0010011};
                bad = |in_imm[31:5];
            end
            OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND: begin
                enc = {1'b0, (in_op == OP_SUB) || (in_op == OP_SRA), 5'b00000,
                       in_rs2, in_rs1, f3, in_rd, 7'b0110011};
            end
            default: bad = 1'b1;
        endcase
        if (bad) enc = NOP;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_inst   <= '0;
            out_addr   <= BASE;
            out_err    <= 1'b0;
            err_sticky <= 1'b0;
            cnt        <= BASE;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_inst  <= enc;
                out_addr  <= load_addr;
                out_err   <= bad;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            cnt        <= load_addr + ADDR_W'(xfer);
            err_sticky <= (restart ? 1'b0 : err_sticky) | (xfer & bad);
        end
    end

endmodule
